// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg: default sizing constants and index-to-one-hot helper        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arb_pkg;

  localparam int unsigned C_NUM_REQ      = 16;
  localparam int unsigned C_REQ_PTR      = 4;
  localparam int unsigned C_MEM_BANK_NUM = 16;
  localparam int unsigned C_BANK_PTR     = 4;
  localparam int unsigned C_WAIT_W       = 4;
  localparam int unsigned C_ONEHOT_W     = 64;

  function automatic logic [C_ONEHOT_W-1:0] idx2onehot(input logic [5:0] idx);
    idx2onehot      = '0;
    idx2onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_rr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: per-bank winner select, round-robin from ptr_i with a       |
// | lowest-index override for starving requesters. Rev 1.0               |
// +----------------------------------------------------------------------+
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = C_NUM_REQ,
  parameter int unsigned REQ_PTR = C_REQ_PTR
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [REQ_PTR-1:0] ptr_i,
  input  logic [NUM_REQ-1:0] starve_i,
  output logic [REQ_PTR-1:0] idx_o,
  output logic               vld_o
);

  logic [REQ_PTR-1:0] rr_idx;
  logic [REQ_PTR-1:0] st_idx;
  logic               rr_found;
  logic               st_found;
  logic [REQ_PTR:0]   sum;
  logic [REQ_PTR-1:0] pos;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    st_idx   = '0;
    st_found = 1'b0;
    sum      = '0;
    pos      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Walk requesters starting at the pointer, wrapping past NUM_REQ-1.
      sum = {1'b0, ptr_i} + (REQ_PTR+1)'(k);
      if (sum >= (REQ_PTR+1)'(NUM_REQ)) sum = sum - (REQ_PTR+1)'(NUM_REQ);
      pos = sum[REQ_PTR-1:0];
      if (!rr_found && elig_i[pos]) begin
        rr_found = 1'b1;
        rr_idx   = pos;
      end
      if (!st_found && elig_i[REQ_PTR'(k)] && starve_i[REQ_PTR'(k)]) begin
        st_found = 1'b1;
        st_idx   = REQ_PTR'(k);
      end
    end
    idx_o = st_found ? st_idx : rr_idx;
    vld_o = rr_found;
  end

endmodule
`default_nettype wire

// File: rtl/bank_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bank_rr_arbiter: per-bank round-robin arbitration of PE FIFO         |
// | requests with starvation override and faulty-bank rejection. Rev 1.0 |
// +----------------------------------------------------------------------+
module bank_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = C_NUM_REQ,
  parameter int unsigned REQ_PTR      = C_REQ_PTR,
  parameter int unsigned MEM_BANK_NUM = C_MEM_BANK_NUM,
  parameter int unsigned BANK_PTR     = C_BANK_PTR,
  parameter int unsigned WAIT_W       = C_WAIT_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*BANK_PTR-1:0]     req_bank,
  input  logic [MEM_BANK_NUM-1:0]         bank_ready,
  input  logic [MEM_BANK_NUM-1:0]         bank_disable,
  output logic [NUM_REQ*MEM_BANK_NUM-1:0] gnt,
  output logic [MEM_BANK_NUM*REQ_PTR-1:0] bank_owner,
  output logic [MEM_BANK_NUM-1:0]         bank_owner_vld,
  output logic [NUM_REQ-1:0]              err_disabled,
  output logic [NUM_REQ-1:0]              starve
);

  localparam logic [WAIT_W-1:0] C_WAIT_MAX = '1;

  logic [NUM_REQ-1:0][MEM_BANK_NUM-1:0] tgt_oh;
  logic [MEM_BANK_NUM-1:0][NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0]                   dis_req;
  logic [NUM_REQ-1:0]                   granted;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic [BANK_PTR-1:0] tgt;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    logic                starve_q;
    logic                err_q;

    assign tgt        = req_bank[i*BANK_PTR +: BANK_PTR];
    assign tgt_oh[i]  = MEM_BANK_NUM'(idx2onehot(6'(tgt)));
    assign dis_req[i] = req_valid[i] & |(tgt_oh[i] & bank_disable);
    assign granted[i] = |gnt[i*MEM_BANK_NUM +: MEM_BANK_NUM];

    // Disabled-bank requests freeze the counter rather than count as waiting.
    always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!req_valid[i] || granted[i]) begin
        wait_cnt_d = '0;
      end else if (!dis_req[i] && (wait_cnt_q != C_WAIT_MAX)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_cnt_q <= '0;
        starve_q   <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        wait_cnt_q <= wait_cnt_d;
        starve_q   <= (wait_cnt_d == C_WAIT_MAX);
        err_q      <= dis_req[i];
      end
    end

    assign starve[i]       = starve_q;
    assign err_disabled[i] = err_q;
  end

  for (genvar b = 0; b < MEM_BANK_NUM; b++) begin : g_bank
    logic [REQ_PTR-1:0] rr_ptr_q;
    logic [REQ_PTR-1:0] rr_ptr_d;
    logic [REQ_PTR-1:0] owner_q;
    logic               owner_vld_q;
    logic [REQ_PTR-1:0] pick_idx;
    logic               pick_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign elig[b][i] = req_valid[i] & tgt_oh[i][b] & bank_ready[b] & ~bank_disable[b];
      // Reset forces every grant low regardless of the pick.
      assign gnt[i*MEM_BANK_NUM+b] = rst_n & pick_vld & (pick_idx == REQ_PTR'(i));
    end

    rr_pick #(
      .NUM_REQ (NUM_REQ),
      .REQ_PTR (REQ_PTR)
    ) u_pick (
      .elig_i   (elig[b]),
      .ptr_i    (rr_ptr_q),
      .starve_i (starve),
      .idx_o    (pick_idx),
      .vld_o    (pick_vld)
    );

    assign rr_ptr_d = !pick_vld                          ? rr_ptr_q :
                      (pick_idx == REQ_PTR'(NUM_REQ-1))  ? '0       :
                                                           pick_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rr_ptr_q    <= '0;
        owner_q     <= '0;
        owner_vld_q <= 1'b0;
      end else begin
        rr_ptr_q    <= rr_ptr_d;
        owner_vld_q <= pick_vld;
        if (pick_vld) owner_q <= pick_idx;
      end
    end

    assign bank_owner[b*REQ_PTR +: REQ_PTR] = owner_q;
    assign bank_owner_vld[b]                = owner_vld_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bank_rr_arbiter: directed and random stimulus, reference model    |
// | feeding a scoreboard queue popped by an independent monitor. Rev 1.0 |
// +----------------------------------------------------------------------+
module tb_bank_rr_arbiter;

  localparam int NR   = 16;
  localparam int NB   = 16;
  localparam int RP   = 4;
  localparam int BP   = 4;
  localparam int WW   = 4;
  localparam int WMAX = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*BP-1:0] req_bank = '0;
  logic [NB-1:0]   bank_ready = '0;
  logic [NB-1:0]   bank_disable = '0;
  logic [NR*NB-1:0] gnt;
  logic [NB*RP-1:0] bank_owner;
  logic [NB-1:0]   bank_owner_vld;
  logic [NR-1:0]   err_disabled;
  logic [NR-1:0]   starve;

  bank_rr_arbiter #(
    .NUM_REQ      (NR),
    .REQ_PTR      (RP),
    .MEM_BANK_NUM (NB),
    .BANK_PTR     (BP),
    .WAIT_W       (WW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_bank       (req_bank),
    .bank_ready     (bank_ready),
    .bank_disable   (bank_disable),
    .gnt            (gnt),
    .bank_owner     (bank_owner),
    .bank_owner_vld (bank_owner_vld),
    .err_disabled   (err_disabled),
    .starve         (starve)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*NB-1:0] gnt;
    logic [NB*RP-1:0] owner;
    logic [NB-1:0]    vld;
    logic [NR-1:0]    err;
    logic [NR-1:0]    stv;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int m_ptr[NB];
  int m_owner[NB];
  int m_vld[NB];
  int m_wait[NR];
  int m_err[NR];
  int cur_bank[NR];

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      m_ptr[b] = 0; m_owner[b] = 0; m_vld[b] = 0;
    end
    for (int i = 0; i < NR; i++) begin
      m_wait[i] = 0; m_err[i] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input bit rn, input logic [NR-1:0] rv, input logic [NB-1:0] rdy,
                      input logic [NB-1:0] dis);
    exp_t e;
    int   win[NB];
    bit   elig;
    int   bestd;
    int   d;
    bit   got;
    @(negedge clk);
    rst_n        = rn;
    req_valid    = rv;
    bank_ready   = rdy;
    bank_disable = dis;
    for (int i = 0; i < NR; i++) req_bank[i*BP +: BP] = BP'(cur_bank[i]);
    #1;
    e.gnt = '0; e.owner = '0; e.vld = '0; e.err = '0; e.stv = '0;
    if (!rn) begin
      model_reset();
    end else begin
      for (int b = 0; b < NB; b++) begin
        e.owner[b*RP +: RP] = RP'(m_owner[b]);
        e.vld[b]            = (m_vld[b] != 0);
      end
      for (int i = 0; i < NR; i++) begin
        e.err[i] = (m_err[i] != 0);
        e.stv[i] = (m_wait[i] == WMAX);
      end
      for (int b = 0; b < NB; b++) begin
        win[b] = -1;
        bestd  = NR;
        for (int i = 0; i < NR; i++) begin
          elig = rv[i] && (cur_bank[i] == b) && rdy[b] && !dis[b];
          if (elig && m_wait[i] == WMAX && win[b] < 0) win[b] = i;
        end
        if (win[b] < 0) begin
          for (int i = 0; i < NR; i++) begin
            elig = rv[i] && (cur_bank[i] == b) && rdy[b] && !dis[b];
            d = (i - m_ptr[b] + NR) % NR;
            if (elig && d < bestd) begin
              bestd  = d;
              win[b] = i;
            end
          end
        end
        if (win[b] >= 0) e.gnt[win[b]*NB + b] = 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        if (win[b] >= 0) begin
          m_ptr[b]   = (win[b] + 1) % NR;
          m_owner[b] = win[b];
          m_vld[b]   = 1;
        end else begin
          m_vld[b] = 0;
        end
      end
      for (int i = 0; i < NR; i++) begin
        got = 1'b0;
        for (int b = 0; b < NB; b++) if (win[b] == i) got = 1'b1;
        m_err[i] = (rv[i] && dis[cur_bank[i]]) ? 1 : 0;
        if (!rv[i] || got)           m_wait[i] = 0;
        else if (dis[cur_bank[i]])   m_wait[i] = m_wait[i];
        else if (m_wait[i] < WMAX)   m_wait[i] = m_wait[i] + 1;
      end
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt",          256'(gnt),            256'(e.gnt));
        chk("bank_owner",   256'(bank_owner),     256'(e.owner));
        chk("owner_vld",    256'(bank_owner_vld), 256'(e.vld));
        chk("err_disabled", 256'(err_disabled),   256'(e.err));
        chk("starve",       256'(starve),         256'(e.stv));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : driver
    logic [NR-1:0] rv;
    logic [NB-1:0] rdy;
    logic [NB-1:0] dis;
    model_reset();
    for (int i = 0; i < NR; i++) cur_bank[i] = 0;
    repeat (3) step(1'b0, '0, '0, '0);

    // Single request: requester 3 -> bank 5.
    cur_bank[3] = 5;
    rv = '0; rv[3] = 1'b1;
    rdy = '0; rdy[5] = 1'b1;
    step(1'b1, rv, rdy, '0);
    step(1'b1, '0, '1, '0);

    // Contention on bank 2 from reset.
    step(1'b0, '0, '0, '0);
    for (int i = 0; i < NR; i++) cur_bank[i] = 0;
    cur_bank[0] = 2; cur_bank[7] = 2; cur_bank[15] = 2;
    rv = '0; rv[0] = 1'b1; rv[7] = 1'b1; rv[15] = 1'b1;
    repeat (4) step(1'b1, rv, '1, '0);
    step(1'b1, '0, '1, '0);

    // Starvation on bank 1, then contention with requester 2.
    step(1'b0, '0, '0, '0);
    cur_bank[9] = 1; cur_bank[2] = 1;
    rv = '0; rv[9] = 1'b1;
    rdy = '1; rdy[1] = 1'b0;
    repeat (15) step(1'b1, rv, rdy, '0);
    rv[2] = 1'b1;
    step(1'b1, rv, '1, '0);
    step(1'b1, '0, '1, '0);

    // Disabled bank 4.
    cur_bank[6] = 4;
    rv = '0; rv[6] = 1'b1;
    dis = '0; dis[4] = 1'b1;
    step(1'b1, rv, '1, dis);
    step(1'b1, '0, '1, dis);
    step(1'b1, '0, '1, '0);

    // All banks in parallel, then a mid-run reset pulse.
    for (int i = 0; i < NR; i++) cur_bank[i] = i;
    step(1'b1, '1, '1, '0);
    step(1'b1, '1, '1, '0);
    step(1'b0, '1, '1, '0);
    step(1'b0, '1, '1, '0);
    step(1'b1, '1, '1, '0);

    // Broad random traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      rv = NR'($urandom);
      for (int i = 0; i < NR; i++) cur_bank[i] = $urandom_range(0, NB-1);
      for (int b = 0; b < NB; b++) begin
        rdy[b] = ($urandom_range(0, 3) != 0);
        dis[b] = ($urandom_range(0, 15) == 0);
      end
      step($urandom_range(0, 99) != 0, rv, rdy, dis);
    end

    // Heavy contention on two mostly-stalled banks to drive starvation.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        rv[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 9) == 0) cur_bank[i] = $urandom_range(0, 1);
        else if (cur_bank[i] > 1)      cur_bank[i] = $urandom_range(0, 1);
      end
      for (int b = 0; b < NB; b++) begin
        rdy[b] = ($urandom_range(0, 7) == 0);
        dis[b] = ($urandom_range(0, 31) == 0);
      end
      step(1'b1, rv, rdy, dis);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_rr_arbiter.md
BANK_RR_ARBITER -- requirements
Module: bank_rr_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- NUM_REQ, 16, number of requesting PE FIFOs
- REQ_PTR, 4, log2(NUM_REQ)
- MEM_BANK_NUM, 16, number of memory banks
- BANK_PTR, 4, log2(MEM_BANK_NUM)
- WAIT_W, 4, starvation counter width
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst_n, in, 1, reset: asynchronous, active-low
- req_valid, in, NUM_REQ, requester i wants a bank this cycle
- req_bank, in, NUM_REQ*BANK_PTR, target bank of requester i, slice [i*BANK_PTR +: BANK_PTR]
- bank_ready, in, MEM_BANK_NUM, bank b can accept an access this cycle
- bank_disable, in, MEM_BANK_NUM, bank b is marked faulty by repair logic
- gnt, out, NUM_REQ*MEM_BANK_NUM, one-hot grant per requester, slice [i*MEM_BANK_NUM +: MEM_BANK_NUM], feeds the FIFO nxt_gnt
- bank_owner, out, MEM_BANK_NUM*REQ_PTR, registered winner index per bank
- bank_owner_vld, out, MEM_BANK_NUM, registered: bank_owner slice valid
- err_disabled, out, NUM_REQ, registered one-cycle pulse: request to a disabled bank
- starve, out, NUM_REQ, registered: requester wait counter saturated

Function
REQ-003 Requester i SHALL be eligible for bank b when req_valid[i]=1, req_bank slice = b, bank_ready[b]=1 and bank_disable[b]=0.
REQ-004 gnt SHALL be combinational from the current inputs and the registered state, with zero-cycle latency.
REQ-005 Each bank SHALL grant at most one requester per cycle, and each requester SHALL hold at most one gnt bit.
REQ-006 Each bank SHALL have a rr_ptr[b] (REQ_PTR bits). Default priority SHALL search eligible requesters from rr_ptr[b] upward, wrapping at NUM_REQ-1 to 0.
REQ-007 Starvation override: if any eligible requester for bank b has starve=1, the lowest-index such requester SHALL win instead of the round-robin choice.
REQ-008 On any grant on bank b, rr_ptr[b] SHALL become (winner+1) mod NUM_REQ at the next edge. Winner NUM_REQ-1 SHALL wrap to 0. With no grant, rr_ptr[b] SHALL hold.
REQ-009 wait_cnt[i] (WAIT_W bits) SHALL behave as follows:
- increment when req_valid[i]=1 and requester i is not granted
- saturate at 2^WAIT_W-1
- clear to 0 on grant or when req_valid[i]=0
- starve[i] SHALL equal (wait_cnt[i] == 2^WAIT_W-1)
REQ-010 A request to a disabled bank SHALL never be granted, SHALL pulse err_disabled[i] in the next cycle, and SHALL NOT advance wait_cnt[i].
REQ-011 bank_owner and bank_owner_vld SHALL register each bank's winner one cycle after the grant. bank_owner_vld[b]=0 SHALL mean no grant occurred, and bank_owner then holds its previous value.
REQ-012 If bank_ready[b]=0, bank b SHALL grant no one, and its rr_ptr and owner outputs SHALL hold with vld=0.
REQ-013 Changes to bank_disable SHALL take effect in the same cycle with no pipeline flush.

Reset
REQ-014 While rst_n=0, all registered state SHALL be 0: rr_ptr, wait_cnt, bank_owner, bank_owner_vld, err_disabled, starve.
REQ-015 During reset gnt SHALL be forced to all zero.
REQ-016 Reset asserted mid-arbitration SHALL discard all priority history. After release, the first grant SHALL follow rr_ptr=0.

Structure
REQ-017 Package arb_pkg SHALL hold the default parameter constants and a function that extracts a one-hot vector from an index.
REQ-018 One sub-module rr_pick SHALL be instantiated once per bank. It takes an eligible vector, a pointer and a starve vector, and returns winner index plus a valid bit.
REQ-019 The implementation SHALL contain no latches and SHALL use a single clock domain.

Verification
REQ-020 Single request: req_valid[3]=1, bank 5 ready -> gnt[3*16+5]=1 in the same cycle; bank_owner[5]=3 and vld=1 in the next cycle; rr_ptr[5]=4.
REQ-021 Contention: requesters 0, 7 and 15 hold bank 2 for 4 cycles from reset -> grant order 0, 7, 15, 0; rr_ptr wraps 0 after winner 15.
REQ-022 Starvation: requester 9 on bank 1 with bank_ready[1]=0 for 15 cycles -> starve[9]=1. Then bank ready with requesters 2 and 9 both requesting, rr_ptr[1]=0 -> 9 wins, and starve[9] clears next cycle.
REQ-023 Disabled bank: bank_disable[4]=1, requester 6 targets bank 4 -> no gnt, err_disabled[6] pulses one cycle, wait_cnt[6] stays 0.
REQ-024 Parallel banks and reset: requesters 0..15 target banks 0..15, all ready -> all 16 granted in the same cycle. rst_n pulsed low mid-run -> gnt=0 immediately and all outputs 0.
